// File: rtl/counter_ctrl.sv
// Front-end controller for a two-digit counter chain: button conditioning,
// count pulse generation with hold-to-repeat, mode/direction/max config, display scan.
module counter_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES     = 16,
   parameter int unsigned REPEAT_CYCLES   = 8,
   parameter int unsigned SCAN_CYCLES     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_cnt,
   input  logic       btn_dir,
   input  logic       btn_mode,
   input  logic       cfg_load,
   input  logic [3:0] cfg_val,
   input  logic [3:0] cnt_lo,
   input  logic [3:0] cnt_hi,
   output logic       inc,
   output logic       up_down_sel,
   output logic       carry_en,
   output logic       max_en,
   output logic [3:0] max_val,
   output logic [1:0] mode,
   output logic       disp_sel,
   output logic [3:0] disp_digit
);

   localparam logic [7:0] DEB_LIM  = 8'(DEBOUNCE_CYCLES);
   localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES);
   localparam logic [7:0] REP_LD   = 8'(REPEAT_CYCLES);
   localparam logic [7:0] SCAN_LIM = 8'(SCAN_CYCLES - 1);

   localparam int unsigned B_CNT  = 0;
   localparam int unsigned B_DIR  = 1;
   localparam int unsigned B_MODE = 2;

   typedef enum logic [1:0] {
      CNT_IDLE   = 2'd0,
      CNT_HOLD   = 2'd1,
      CNT_REPEAT = 2'd2
   } cnt_state_e;

   typedef enum logic [1:0] {
      MODE_FREE  = 2'd0,
      MODE_CARRY = 2'd1,
      MODE_MAX   = 2'd2
   } mode_e;

   logic [2:0]      btn_raw;
   logic [2:0]      sync1_q, sync1_d;
   logic [2:0]      sync2_q, sync2_d;
   logic [2:0]      db_q, db_d;
   logic [2:0]      db_prev_q, db_prev_d;
   logic [2:0][7:0] dbc_q, dbc_d;
   logic [2:0]      press;

   cnt_state_e      cnt_state_q, cnt_state_d;
   logic [7:0]      timer_q, timer_d;
   logic            inc_q, inc_d;

   mode_e           mode_q, mode_d;
   logic            dir_q, dir_d;
   logic [3:0]      max_val_q, max_val_d;
   logic            accept;

   logic [7:0]      scan_q, scan_d;
   logic            disp_sel_q, disp_sel_d;
   logic [3:0]      disp_digit_q, disp_digit_d;

   assign btn_raw = {btn_mode, btn_dir, btn_cnt};

   // A level change is accepted only after the synchronized level has
   // disagreed with the debounced level for DEBOUNCE_CYCLES cycles in a row.
   always_comb begin
      sync1_d   = btn_raw;
      sync2_d   = sync1_q;
      db_prev_d = db_q;
      db_d      = db_q;
      dbc_d     = dbc_q;
      for (int unsigned i = 0; i < 3; i++) begin
         if (sync2_q[i] != db_q[i]) begin
            if (dbc_q[i] == DEB_LIM) begin
               db_d[i]  = ~db_q[i];
               dbc_d[i] = '0;
            end else begin
               dbc_d[i] = dbc_q[i] + 8'd1;
            end
         end else begin
            dbc_d[i] = '0;
         end
      end
      press = db_q & ~db_prev_q;
   end

   always_comb begin
      cnt_state_d = cnt_state_q;
      timer_d     = timer_q;
      inc_d       = 1'b0;
      unique case (cnt_state_q)
         CNT_IDLE: begin
            if (press[B_CNT]) begin
               inc_d       = 1'b1;
               timer_d     = HOLD_LD;
               cnt_state_d = CNT_HOLD;
            end
         end
         CNT_HOLD, CNT_REPEAT: begin
            // Release wins over an expiry in the same cycle.
            if (!db_q[B_CNT]) begin
               cnt_state_d = CNT_IDLE;
            end else if (timer_q <= 8'd1) begin
               inc_d       = 1'b1;
               timer_d     = REP_LD;
               cnt_state_d = CNT_REPEAT;
            end else begin
               timer_d = timer_q - 8'd1;
            end
         end
         default: cnt_state_d = CNT_IDLE;
      endcase
   end

   always_comb begin
      accept    = (cnt_state_q == CNT_IDLE);
      mode_d    = mode_q;
      dir_d     = dir_q;
      max_val_d = max_val_q;
      if (accept && press[B_DIR]) begin
         dir_d = ~dir_q;
      end
      if (accept && press[B_MODE]) begin
         unique case (mode_q)
            MODE_FREE:  mode_d = MODE_CARRY;
            MODE_CARRY: mode_d = MODE_MAX;
            default:    mode_d = MODE_FREE;
         endcase
      end
      if (cfg_load) begin
         max_val_d = cfg_val;
      end
   end

   always_comb begin
      scan_d       = scan_q + 8'd1;
      disp_sel_d   = disp_sel_q;
      disp_digit_d = disp_sel_q ? cnt_hi : cnt_lo;
      if (scan_q >= SCAN_LIM) begin
         scan_d     = '0;
         disp_sel_d = ~disp_sel_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         db_q         <= '0;
         db_prev_q    <= '0;
         dbc_q        <= '0;
         cnt_state_q  <= CNT_IDLE;
         timer_q      <= '0;
         inc_q        <= 1'b0;
         mode_q       <= MODE_FREE;
         dir_q        <= 1'b0;
         max_val_q    <= 4'd9;
         scan_q       <= '0;
         disp_sel_q   <= 1'b0;
         disp_digit_q <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         db_q         <= db_d;
         db_prev_q    <= db_prev_d;
         dbc_q        <= dbc_d;
         cnt_state_q  <= cnt_state_d;
         timer_q      <= timer_d;
         inc_q        <= inc_d;
         mode_q       <= mode_d;
         dir_q        <= dir_d;
         max_val_q    <= max_val_d;
         scan_q       <= scan_d;
         disp_sel_q   <= disp_sel_d;
         disp_digit_q <= disp_digit_d;
      end
   end

   assign inc         = inc_q;
   assign up_down_sel = dir_q;
   assign carry_en    = (mode_q == MODE_CARRY);
   assign max_en      = (mode_q == MODE_MAX);
   assign max_val     = max_val_q;
   assign mode        = mode_q;
   assign disp_sel    = disp_sel_q;
   assign disp_digit  = disp_digit_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with default parameters; edge n counts from
// the first edge that samples a new raw button level.
module tb_counter_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_cnt, btn_dir, btn_mode, cfg_load;
   logic [3:0] cfg_val, cnt_lo, cnt_hi;
   logic       inc, up_down_sel, carry_en, max_en, disp_sel;
   logic [3:0] max_val, disp_digit;
   logic [1:0] mode;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   counter_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES    (16),
      .REPEAT_CYCLES  (8),
      .SCAN_CYCLES    (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_cnt    (btn_cnt),
      .btn_dir    (btn_dir),
      .btn_mode   (btn_mode),
      .cfg_load   (cfg_load),
      .cfg_val    (cfg_val),
      .cnt_lo     (cnt_lo),
      .cnt_hi     (cnt_hi),
      .inc        (inc),
      .up_down_sel(up_down_sel),
      .carry_en   (carry_en),
      .max_en     (max_en),
      .max_val    (max_val),
      .mode       (mode),
      .disp_sel   (disp_sel),
      .disp_digit (disp_digit)
   );

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks += 8;
      if (inc !== 1'b0) begin errors++; $display("FAIL reset_inc got %0b exp 0", inc); end
      if (up_down_sel !== 1'b0) begin errors++; $display("FAIL reset_dir got %0b exp 0", up_down_sel); end
      if (carry_en !== 1'b0) begin errors++; $display("FAIL reset_carry got %0b exp 0", carry_en); end
      if (max_en !== 1'b0) begin errors++; $display("FAIL reset_max_en got %0b exp 0", max_en); end
      if (max_val !== 4'd9) begin errors++; $display("FAIL reset_max_val got %0d exp 9", max_val); end
      if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d exp 0", mode); end
      if (disp_sel !== 1'b0) begin errors++; $display("FAIL reset_disp_sel got %0b exp 0", disp_sel); end
      if (disp_digit !== 4'd0) begin errors++; $display("FAIL reset_disp_digit got %0d exp 0", disp_digit); end
   endtask

   task automatic test_display();
      logic       exp_sel;
      logic [3:0] exp_dig;
      cnt_lo = 4'd3;
      cnt_hi = 4'd7;
      reset  = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (disp_digit !== 4'd0) begin errors++; $display("FAIL disp_reset got %0d exp 0", disp_digit); end
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk);
         #1;
         exp_sel = ((k / 4) % 2) == 1;
         exp_dig = (((k - 1) / 4) % 2 == 1) ? 4'd7 : 4'd3;
         checks += 2;
         if (disp_sel !== exp_sel) begin errors++; $display("FAIL disp_sel k=%0d got %0b exp %0b", k, disp_sel, exp_sel); end
         if (disp_digit !== exp_dig) begin errors++; $display("FAIL disp_digit k=%0d got %0d exp %0d", k, disp_digit, exp_dig); end
      end
   endtask

   task automatic test_single_press();
      btn_cnt = 1'b1;
      for (int n = 0; n <= 40; n++) begin
         @(posedge clk);
         #1;
         checks++;
         if (inc !== (n == 7)) begin errors++; $display("FAIL single_inc n=%0d got %0b exp %0b", n, inc, (n == 7)); end
         if (n == 9) btn_cnt = 1'b0;
      end
   endtask

   task automatic test_hold_repeat();
      logic exp;
      btn_cnt = 1'b1;
      for (int n = 0; n <= 80; n++) begin
         @(posedge clk);
         #1;
         exp = (n == 7) || (n >= 23 && n <= 55 && ((n - 23) % 8) == 0);
         checks++;
         if (inc !== exp) begin errors++; $display("FAIL repeat_inc n=%0d got %0b exp %0b", n, inc, exp); end
         // Debounced release lands exactly on the edge-63 repeat expiry.
         if (n == 55) btn_cnt = 1'b0;
      end
   endtask

   task automatic test_glitch();
      btn_cnt = 1'b1;
      for (int n = 0; n <= 29; n++) begin
         @(posedge clk);
         #1;
         checks++;
         if (inc !== 1'b0) begin errors++; $display("FAIL glitch_inc n=%0d got %0b exp 0", n, inc); end
         if (n == 2)  btn_cnt  = 1'b0;
         if (n == 10) btn_mode = 1'b1;
         if (n == 12) btn_mode = 1'b0;
      end
      checks += 3;
      if (mode !== 2'd0) begin errors++; $display("FAIL glitch_mode got %0d exp 0", mode); end
      if (carry_en !== 1'b0) begin errors++; $display("FAIL glitch_carry got %0b exp 0", carry_en); end
      if (max_en !== 1'b0) begin errors++; $display("FAIL glitch_max_en got %0b exp 0", max_en); end
   endtask

   task automatic test_mode_dir();
      logic [1:0] old_m, new_m;
      for (int p = 0; p < 4; p++) begin
         old_m = 2'(p % 3);
         new_m = 2'((p + 1) % 3);
         btn_mode = 1'b1;
         for (int n = 0; n <= 25; n++) begin
            @(posedge clk);
            #1;
            if (n == 6) begin
               checks++;
               if (mode !== old_m) begin errors++; $display("FAIL mode_early p=%0d got %0d exp %0d", p, mode, old_m); end
            end
            if (n == 7) begin
               checks += 3;
               if (mode !== new_m) begin errors++; $display("FAIL mode_step p=%0d got %0d exp %0d", p, mode, new_m); end
               if (carry_en !== (new_m == 2'd1)) begin errors++; $display("FAIL mode_carry p=%0d got %0b exp %0b", p, carry_en, (new_m == 2'd1)); end
               if (max_en !== (new_m == 2'd2)) begin errors++; $display("FAIL mode_max_en p=%0d got %0b exp %0b", p, max_en, (new_m == 2'd2)); end
            end
            if (n == 9) btn_mode = 1'b0;
         end
      end
      btn_dir = 1'b1;
      for (int n = 0; n <= 25; n++) begin
         @(posedge clk);
         #1;
         if (n == 6 || n == 7) begin
            checks++;
            if (up_down_sel !== (n == 7)) begin errors++; $display("FAIL dir_toggle n=%0d got %0b exp %0b", n, up_down_sel, (n == 7)); end
         end
         if (n == 9) btn_dir = 1'b0;
      end
   endtask

   task automatic test_repeat_lockout_cfg_reset();
      logic exp;
      cfg_val  = 4'd12;
      cfg_load = 1'b0;
      btn_cnt  = 1'b1;
      for (int n = 0; n <= 42; n++) begin
         @(posedge clk);
         #1;
         exp = (n == 7) || (n == 23) || (n == 31) || (n == 39);
         checks++;
         if (inc !== exp) begin errors++; $display("FAIL lock_inc n=%0d got %0b exp %0b", n, inc, exp); end
         if (n == 33 || n == 40) begin
            checks += 2;
            if (mode !== 2'd1) begin errors++; $display("FAIL lock_mode n=%0d got %0d exp 1", n, mode); end
            if (carry_en !== 1'b1) begin errors++; $display("FAIL lock_carry n=%0d got %0b exp 1", n, carry_en); end
         end
         if (n == 33) begin
            checks++;
            if (max_val !== 4'd9) begin errors++; $display("FAIL cfg_ignored got %0d exp 9", max_val); end
         end
         if (n == 34) begin
            checks++;
            if (max_val !== 4'd5) begin errors++; $display("FAIL cfg_load got %0d exp 5", max_val); end
         end
         if (n == 24) btn_mode = 1'b1;
         if (n == 34) btn_mode = 1'b0;
         if (n == 33) begin cfg_load = 1'b1; cfg_val = 4'd5; end
         if (n == 34) begin cfg_load = 1'b0; cfg_val = 4'd12; end
         if (n == 42) begin reset = 1'b1; btn_cnt = 1'b0; end
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks += 6;
      if (inc !== 1'b0) begin errors++; $display("FAIL midrst_inc got %0b exp 0", inc); end
      if (up_down_sel !== 1'b0) begin errors++; $display("FAIL midrst_dir got %0b exp 0", up_down_sel); end
      if (carry_en !== 1'b0) begin errors++; $display("FAIL midrst_carry got %0b exp 0", carry_en); end
      if (max_en !== 1'b0) begin errors++; $display("FAIL midrst_max_en got %0b exp 0", max_en); end
      if (max_val !== 4'd9) begin errors++; $display("FAIL midrst_max_val got %0d exp 9", max_val); end
      if (mode !== 2'd0) begin errors++; $display("FAIL midrst_mode got %0d exp 0", mode); end
      for (int n = 0; n < 30; n++) begin
         @(posedge clk);
         #1;
         checks++;
         if (inc !== 1'b0) begin errors++; $display("FAIL postrst_inc n=%0d got %0b exp 0", n, inc); end
      end
   endtask

   task automatic test_fresh_press_with_cfg();
      btn_cnt  = 1'b1;
      btn_mode = 1'b1;
      for (int n = 0; n <= 25; n++) begin
         @(posedge clk);
         #1;
         checks++;
         if (inc !== (n == 7)) begin errors++; $display("FAIL fresh_inc n=%0d got %0b exp %0b", n, inc, (n == 7)); end
         if (n == 7) begin
            checks += 2;
            if (mode !== 2'd1) begin errors++; $display("FAIL both_mode got %0d exp 1", mode); end
            if (max_val !== 4'd3) begin errors++; $display("FAIL both_max_val got %0d exp 3", max_val); end
         end
         if (n == 6) begin cfg_load = 1'b1; cfg_val = 4'd3; end
         if (n == 7) begin cfg_load = 1'b0; cfg_val = 4'd0; end
         if (n == 9) begin btn_cnt = 1'b0; btn_mode = 1'b0; end
      end
   endtask

   initial begin
      reset    = 1'b1;
      btn_cnt  = 1'b0;
      btn_dir  = 1'b0;
      btn_mode = 1'b0;
      cfg_load = 1'b0;
      cfg_val  = 4'd0;
      cnt_lo   = 4'd0;
      cnt_hi   = 4'd0;
      test_reset();
      test_display();
      repeat (5) @(posedge clk);
      #1;
      test_single_press();
      test_hold_repeat();
      test_glitch();
      test_mode_dir();
      test_repeat_lockout_cfg_reset();
      test_fresh_press_with_cfg();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
